// File: rtl/tmc_tsched_pkg.sv
// Shared types and constants for the interval-timer scheduler.
// Build option: TMC_TSCHED_WDOG_EN adds a watchdog on the irq wait.
package tmc_tsched_pkg;

   typedef enum logic [3:0] {
      IDLE          = 4'd0,
      ARB           = 4'd1,
      WR_STOP       = 4'd2,
      WR_PL         = 4'd3,
      WR_PH         = 4'd4,
      WR_CTRL       = 4'd5,
      WAIT_IRQ      = 4'd6,
      WR_ABORT_STOP = 4'd7,
      WR_CLR        = 4'd8,
      DONE          = 4'd9
   } state_t;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam logic [15:0] CTRL_STOP_WORD  = 16'h0001 << CTRL_STOP;
   localparam logic [15:0] CTRL_START_WORD = (16'h0001 << CTRL_START) | (16'h0001 << CTRL_ITO);

   localparam logic [31:0] WDOG_MARGIN = 32'd64;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/tmc_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after pointer, wrapping.
module tmc_rr_arbiter
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       pointer,
   output logic [N_REQ-1:0] grant,
   output logic [2:0]       index
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [3:0] cand;

   // Scan from the farthest candidate back to pointer so the nearest one wins.
   always_comb begin
      grant = '0;
      index = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, pointer} + 4'(k);
         if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
         if (req[cand[IW-1:0]]) begin
            grant = '0;
            grant[cand[IW-1:0]] = 1'b1;
            index = cand[2:0];
         end
      end
   end

endmodule

// File: rtl/tmc_timer_sched.sv
// Shares one Avalon interval timer among N_REQ one-shot delay requesters.
// Build option: TMC_TSCHED_WDOG_EN adds the irq watchdog and the wdog_err port.
module tmc_timer_sched
   import tmc_tsched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MIN_DELAY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  delay,
   input  logic [N_REQ-1:0]     abort,
   output logic [N_REQ-1:0]     ack,
   output logic                 aborted,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic [2:0]           tmr_address,
   output logic                 tmr_chipselect,
   output logic                 tmr_write_n,
   output logic [15:0]          tmr_writedata,
   input  logic                 tmr_irq,
   output logic [3:0]           dbg_state
`ifdef TMC_TSCHED_WDOG_EN
   ,
   output logic                 wdog_err
`endif
);

   // Handshake: req is a level held until a one-cycle ack; the owner drops it
   // the cycle after ack, otherwise it is arbitrated again as a new request.

   state_t           state;
   logic [2:0]       pointer;
   logic [N_REQ-1:0] owner_oh;
   logic [N_REQ-1:0] arb_grant;
   logic [2:0]       arb_index;
   logic [2:0]       next_ptr;
   logic [31:0]      d_r;
   logic [31:0]      period;
   logic [31:0]      owner_delay;
   logic             aborted_r;

   tmc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .pointer (pointer),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   always_comb begin
      owner_delay = '0;
      for (int i = 0; i < N_REQ; i++)
         if (owner_oh[i]) owner_delay = delay[32*i +: 32];
   end

   assign next_ptr  = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
   assign period    = d_r - 32'd1;
   assign dbg_state = state;

`ifdef TMC_TSCHED_WDOG_EN
   logic [31:0] wdog_cnt;
   logic [31:0] wdog_limit;
   assign wdog_limit = sat_add32(d_r, WDOG_MARGIN);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         pointer        <= '0;
         owner          <= '0;
         owner_oh       <= '0;
         d_r            <= '0;
         aborted_r      <= 1'b0;
         ack            <= '0;
         aborted        <= 1'b0;
         busy           <= 1'b0;
         tmr_address    <= '0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_writedata  <= '0;
`ifdef TMC_TSCHED_WDOG_EN
         wdog_cnt       <= '0;
         wdog_err       <= 1'b0;
`endif
      end else begin
         // Bus writes and ack are single-cycle: default everything idle.
         ack            <= '0;
         aborted        <= 1'b0;
         tmr_address    <= '0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_writedata  <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state    <= ARB;
                  busy     <= 1'b1;
                  owner    <= arb_index;
                  owner_oh <= arb_grant;
               end
            end
            ARB: begin
               d_r       <= owner_delay;
               pointer   <= next_ptr;
               aborted_r <= 1'b0;
               if (owner_delay < 32'(MIN_DELAY)) begin
                  state <= DONE;
                  ack   <= owner_oh;
               end else begin
                  state          <= WR_STOP;
                  tmr_chipselect <= 1'b1;
                  tmr_write_n    <= 1'b0;
                  tmr_address    <= ADDR_CONTROL;
                  tmr_writedata  <= CTRL_STOP_WORD;
               end
            end
            WR_STOP: begin
               state          <= WR_PL;
               tmr_chipselect <= 1'b1;
               tmr_write_n    <= 1'b0;
               tmr_address    <= ADDR_PERIODL;
               tmr_writedata  <= period[15:0];
            end
            WR_PL: begin
               state          <= WR_PH;
               tmr_chipselect <= 1'b1;
               tmr_write_n    <= 1'b0;
               tmr_address    <= ADDR_PERIODH;
               tmr_writedata  <= period[31:16];
            end
            // Start only after both period writes: each one stops the timer.
            WR_PH: begin
               state          <= WR_CTRL;
               tmr_chipselect <= 1'b1;
               tmr_write_n    <= 1'b0;
               tmr_address    <= ADDR_CONTROL;
               tmr_writedata  <= CTRL_START_WORD;
            end
            WR_CTRL: begin
               state <= WAIT_IRQ;
`ifdef TMC_TSCHED_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            WAIT_IRQ: begin
               if (tmr_irq) begin
                  state          <= WR_CLR;
                  aborted_r      <= 1'b0;
                  tmr_chipselect <= 1'b1;
                  tmr_write_n    <= 1'b0;
                  tmr_address    <= ADDR_STATUS;
               end else if (|(abort & owner_oh)) begin
                  state          <= WR_ABORT_STOP;
                  aborted_r      <= 1'b1;
                  tmr_chipselect <= 1'b1;
                  tmr_write_n    <= 1'b0;
                  tmr_address    <= ADDR_CONTROL;
                  tmr_writedata  <= CTRL_STOP_WORD;
               end
`ifdef TMC_TSCHED_WDOG_EN
               else if (wdog_cnt >= wdog_limit) begin
                  state          <= WR_ABORT_STOP;
                  aborted_r      <= 1'b1;
                  wdog_err       <= 1'b1;
                  tmr_chipselect <= 1'b1;
                  tmr_write_n    <= 1'b0;
                  tmr_address    <= ADDR_CONTROL;
                  tmr_writedata  <= CTRL_STOP_WORD;
               end else if (wdog_cnt != 32'hFFFF_FFFF) begin
                  wdog_cnt <= wdog_cnt + 32'd1;
               end
`endif
            end
            WR_ABORT_STOP: begin
               state          <= WR_CLR;
               tmr_chipselect <= 1'b1;
               tmr_write_n    <= 1'b0;
               tmr_address    <= ADDR_STATUS;
            end
            WR_CLR: begin
               state   <= DONE;
               ack     <= owner_oh;
               aborted <= aborted_r;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tmc_timer_sched.sv
// Directed bench for tmc_timer_sched with a behavioural interval-timer model.
// Build option: TMC_TSCHED_WDOG_EN enables the watchdog scenario.
module tb_tmc_timer_sched;

   localparam int N = 4;

   logic            clk;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [32*N-1:0] delay;
   logic [N-1:0]    abort;
   logic [N-1:0]    ack;
   logic            aborted;
   logic            busy;
   logic [2:0]      owner;
   logic [2:0]      tmr_address;
   logic            tmr_chipselect;
   logic            tmr_write_n;
   logic [15:0]     tmr_writedata;
   logic            tmr_irq;
   logic [3:0]      dbg_state;
`ifdef TMC_TSCHED_WDOG_EN
   logic            wdog_err;
`endif

   int checks = 0;
   int failures = 0;

   tmc_timer_sched #(.N_REQ(N), .MIN_DELAY(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .delay          (delay),
      .abort          (abort),
      .ack            (ack),
      .aborted        (aborted),
      .busy           (busy),
      .owner          (owner),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq),
      .dbg_state      (dbg_state)
`ifdef TMC_TSCHED_WDOG_EN
      ,
      .wdog_err       (wdog_err)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- interval timer model ----------------
   logic [15:0] t_pl, t_ph;
   logic [31:0] t_cnt;
   logic        t_run, t_to, t_ito;
   logic        irq_block;

   assign tmr_irq = t_to & t_ito & ~irq_block;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_pl <= '0; t_ph <= '0; t_cnt <= '0;
         t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
      end else begin
         if (t_run) begin
            if (t_cnt == 32'd0) begin
               t_to  <= 1'b1;
               t_run <= 1'b0;
               t_cnt <= {t_ph, t_pl};
            end else begin
               t_cnt <= t_cnt - 32'd1;
            end
         end
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               3'd0: t_to <= 1'b0;
               3'd1: begin
                  t_ito <= tmr_writedata[0];
                  if (tmr_writedata[3]) t_run <= 1'b0;
                  else if (tmr_writedata[2]) t_run <= 1'b1;
               end
               3'd2: begin t_pl <= tmr_writedata; t_run <= 1'b0; t_cnt <= {t_ph, tmr_writedata}; end
               3'd3: begin t_ph <= tmr_writedata; t_run <= 1'b0; t_cnt <= {tmr_writedata, t_pl}; end
               default: ;
            endcase
         end
      end
   end

   // Log of bus writes as {address, data}.
   logic [18:0] wr_q[$];
   always @(posedge clk)
      if (tmr_chipselect && !tmr_write_n) wr_q.push_back({tmr_address, tmr_writedata});

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset_n = 1'b0;
      req = '0; abort = '0; delay = '0; irq_block = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wr_q.delete();
   endtask

   task automatic set_delay(input int ch, input logic [31:0] d);
      delay[32*ch +: 32] = d;
   endtask

   // Runs until an ack or the budget expires (n_ack = -1). Optionally pulses
   // abort at loop step ab_at, or whenever irq is seen.
   task automatic wait_ack(input int budget, input logic [N-1:0] ab_mask, input int ab_at,
                           input bit ab_on_irq, output int n_ack, output logic [N-1:0] ack_v,
                           output logic ab_v, output logic [2:0] own_v,
                           output int ctrl_n, output int irq_n);
      n_ack = -1; ack_v = '0; ab_v = 1'b0; own_v = '0; ctrl_n = -1; irq_n = -1;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk); #1;
         if (ctrl_n < 0 && tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 &&
             tmr_writedata == 16'h0005) ctrl_n = n;
         if (irq_n < 0 && tmr_irq) irq_n = n;
         if (|ack) begin
            n_ack = n; ack_v = ack; ab_v = aborted; own_v = owner;
            req = req & ~ack;
            break;
         end
         abort = ((n == ab_at) || (ab_on_irq && tmr_irq)) ? ab_mask : '0;
      end
      abort = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (ack !== 4'b0)          begin failures++; $display("FAIL reset_ack: got %b exp 0", ack); end
      checks++; if (aborted !== 1'b0)      begin failures++; $display("FAIL reset_aborted: got %b exp 0", aborted); end
      checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (owner !== 3'd0)        begin failures++; $display("FAIL reset_owner: got %0d exp 0", owner); end
      checks++; if (tmr_chipselect !== 1'b0) begin failures++; $display("FAIL reset_cs: got %b exp 0", tmr_chipselect); end
      checks++; if (tmr_write_n !== 1'b1)  begin failures++; $display("FAIL reset_write_n: got %b exp 1", tmr_write_n); end
      checks++; if (tmr_address !== 3'd0)  begin failures++; $display("FAIL reset_addr: got %0d exp 0", tmr_address); end
      checks++; if (tmr_writedata !== 16'h0) begin failures++; $display("FAIL reset_data: got %h exp 0", tmr_writedata); end
      checks++; if (dbg_state !== 4'd0)    begin failures++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
`ifdef TMC_TSCHED_WDOG_EN
      checks++; if (wdog_err !== 1'b0)     begin failures++; $display("FAIL reset_wdog_err: got %b exp 0", wdog_err); end
`endif
   endtask

   task automatic test_single();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      logic [18:0] exp_w[$];
      logic [18:0] got;
      exp_w = '{19'h10008, 19'h20063, 19'h30000, 19'h10005, 19'h00000};
      wr_q.delete();
      set_delay(0, 32'd100);
      req = 4'b0001;
      wait_ack(300, '0, -1, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== 108)      begin failures++; $display("FAIL single_latency: got %0d exp 108", n); end
      checks++; if (a !== 4'b0001)  begin failures++; $display("FAIL single_ack: got %b exp 0001", a); end
      checks++; if (ab !== 1'b0)    begin failures++; $display("FAIL single_aborted: got %b exp 0", ab); end
      checks++; if (ow !== 3'd0)    begin failures++; $display("FAIL single_owner: got %0d exp 0", ow); end
      // irq rises D edges after the edge that accepts the control write.
      checks++; if (in - cn !== 101) begin failures++; $display("FAIL single_irq_delay: got %0d exp 101", in - cn); end
      checks++; if (wr_q.size() !== 5) begin failures++; $display("FAIL single_nwrites: got %0d exp 5", wr_q.size()); end
      for (int i = 0; i < exp_w.size(); i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 19'h7FFFF;
         checks++; if (got !== exp_w[i]) begin failures++; $display("FAIL single_write%0d: got %h exp %h", i, got, exp_w[i]); end
      end
      @(posedge clk); #1;
      checks++; if (ack !== 4'b0)   begin failures++; $display("FAIL single_ack_pulse: got %b exp 0", ack); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL single_idle: got %b exp 0", busy); end
   endtask

   task automatic test_large();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      logic [18:0] exp_w[$];
      logic [18:0] got;
      exp_w = '{19'h10008, 19'h20004, 19'h30002, 19'h10005, 19'h10008, 19'h00000};
      wr_q.delete();
      set_delay(1, 32'h0002_0005);
      req = 4'b0010;
      wait_ack(100, 4'b0010, 30, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== 33)       begin failures++; $display("FAIL large_latency: got %0d exp 33", n); end
      checks++; if (a !== 4'b0010)  begin failures++; $display("FAIL large_ack: got %b exp 0010", a); end
      checks++; if (ab !== 1'b1)    begin failures++; $display("FAIL large_aborted: got %b exp 1", ab); end
      checks++; if (wr_q.size() !== 6) begin failures++; $display("FAIL large_nwrites: got %0d exp 6", wr_q.size()); end
      for (int i = 0; i < exp_w.size(); i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 19'h7FFFF;
         checks++; if (got !== exp_w[i]) begin failures++; $display("FAIL large_write%0d: got %h exp %h", i, got, exp_w[i]); end
      end
      @(posedge clk);
   endtask

   task automatic test_abort();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      wr_q.delete();
      set_delay(2, 32'd1000);
      req = 4'b0100;
      // Abort on every channel but the owner must be ignored.
      wait_ack(40, 4'b1011, 20, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== -1)       begin failures++; $display("FAIL abort_nonowner: got ack at %0d exp none", n); end
      checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL abort_nonowner_busy: got %b exp 1", busy); end
      wait_ack(20, 4'b0100, 5, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== 8)        begin failures++; $display("FAIL abort_latency: got %0d exp 8", n); end
      checks++; if (a !== 4'b0100)  begin failures++; $display("FAIL abort_ack: got %b exp 0100", a); end
      checks++; if (ab !== 1'b1)    begin failures++; $display("FAIL abort_aborted: got %b exp 1", ab); end
      checks++; if (in !== -1)      begin failures++; $display("FAIL abort_irq_seen: got %0d exp -1", in); end
      checks++; if (wr_q.size() !== 6) begin failures++; $display("FAIL abort_nwrites: got %0d exp 6", wr_q.size()); end
      if (wr_q.size() >= 2) begin
         checks++; if (wr_q[wr_q.size()-2] !== 19'h10008) begin failures++; $display("FAIL abort_stop_write: got %h exp 10008", wr_q[wr_q.size()-2]); end
         checks++; if (wr_q[wr_q.size()-1] !== 19'h00000) begin failures++; $display("FAIL abort_clr_write: got %h exp 00000", wr_q[wr_q.size()-1]); end
      end
      @(posedge clk);
   endtask

   task automatic test_same_cycle();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      set_delay(3, 32'd4);
      req = 4'b1000;
      wait_ack(50, 4'b1000, -1, 1'b1, n, a, ab, ow, cn, in);
      checks++; if (n !== 12)       begin failures++; $display("FAIL same_latency: got %0d exp 12", n); end
      checks++; if (a !== 4'b1000)  begin failures++; $display("FAIL same_ack: got %b exp 1000", a); end
      checks++; if (ab !== 1'b0)    begin failures++; $display("FAIL same_aborted: got %b exp 0", ab); end
      @(posedge clk);
   endtask

   task automatic test_min_delay();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      for (int d = 0; d < 2; d++) begin
         wr_q.delete();
         set_delay(d, 32'(d));
         req = 4'(1 << d);
         wait_ack(10, '0, -1, 1'b0, n, a, ab, ow, cn, in);
         checks++; if (n !== 2)        begin failures++; $display("FAIL min%0d_latency: got %0d exp 2", d, n); end
         checks++; if (a !== 4'(1 << d)) begin failures++; $display("FAIL min%0d_ack: got %b exp %b", d, a, 4'(1 << d)); end
         checks++; if (ab !== 1'b0)    begin failures++; $display("FAIL min%0d_aborted: got %b exp 0", d, ab); end
         @(posedge clk); #1;
         checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL min%0d_bus: got %0d writes exp 0", d, wr_q.size()); end
      end
   endtask

   task automatic test_round_robin();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      int exp_g[$];
      do_reset();
      for (int c = 0; c < N; c++) set_delay(c, 32'd3);
      req = 4'b1111;
      exp_g = '{0, 1, 2, 3};
      for (int g = 0; g < 4; g++) begin
         wait_ack(50, '0, -1, 1'b0, n, a, ab, ow, cn, in);
         checks++; if (a !== 4'(1 << exp_g[g])) begin failures++; $display("FAIL rr_grant%0d: got %b exp %b", g, a, 4'(1 << exp_g[g])); end
         checks++; if (ow !== 3'(exp_g[g]))     begin failures++; $display("FAIL rr_owner%0d: got %0d exp %0d", g, ow, exp_g[g]); end
      end
      req = 4'b0101;
      exp_g = '{0, 2};
      for (int g = 0; g < 2; g++) begin
         wait_ack(50, '0, -1, 1'b0, n, a, ab, ow, cn, in);
         checks++; if (a !== 4'(1 << exp_g[g])) begin failures++; $display("FAIL rr_regrant%0d: got %b exp %b", g, a, 4'(1 << exp_g[g])); end
      end
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      logic [18:0] exp_w[$];
      logic [18:0] got;
      exp_w = '{19'h10008, 19'h20031, 19'h30000, 19'h10005, 19'h00000};
      set_delay(1, 32'd50);
      req = 4'b0010;
      wait_ack(20, '0, -1, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== -1)       begin failures++; $display("FAIL rmid_no_ack: got %0d exp -1", n); end
      checks++; if (dbg_state !== 4'd6) begin failures++; $display("FAIL rmid_waiting: got %0d exp 6", dbg_state); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rmid_busy: got %b exp 0", busy); end
      checks++; if (dbg_state !== 4'd0) begin failures++; $display("FAIL rmid_state: got %0d exp 0", dbg_state); end
      checks++; if (tmr_write_n !== 1'b1 || tmr_chipselect !== 1'b0) begin failures++; $display("FAIL rmid_bus: got cs=%b wn=%b exp cs=0 wn=1", tmr_chipselect, tmr_write_n); end
      repeat (2) @(negedge clk);
      wr_q.delete();
      reset_n = 1'b1;
      wait_ack(100, '0, -1, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== 58)       begin failures++; $display("FAIL rmid_latency: got %0d exp 58", n); end
      checks++; if (ab !== 1'b0)    begin failures++; $display("FAIL rmid_aborted: got %b exp 0", ab); end
      for (int i = 0; i < exp_w.size(); i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 19'h7FFFF;
         checks++; if (got !== exp_w[i]) begin failures++; $display("FAIL rmid_write%0d: got %h exp %h", i, got, exp_w[i]); end
      end
      @(posedge clk);
   endtask

`ifdef TMC_TSCHED_WDOG_EN
   task automatic test_wdog();
      int n, cn, in;
      logic [N-1:0] a;
      logic ab;
      logic [2:0] ow;
      irq_block = 1'b1;
      set_delay(0, 32'd10);
      req = 4'b0001;
      wait_ack(200, '0, -1, 1'b0, n, a, ab, ow, cn, in);
      checks++; if (n !== 83)       begin failures++; $display("FAIL wdog_latency: got %0d exp 83", n); end
      checks++; if (ab !== 1'b1)    begin failures++; $display("FAIL wdog_aborted: got %b exp 1", ab); end
      checks++; if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_err: got %b exp 1", wdog_err); end
      irq_block = 1'b0;
      @(posedge clk);
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_large();
      test_abort();
      test_same_cycle();
      test_min_delay();
      test_round_robin();
      test_reset_mid();
`ifdef TMC_TSCHED_WDOG_EN
      test_wdog();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
